// File: rtl/data_mem_responder.sv
// Load/store responder on a word-organised RAM with fixed, programmable response latency.
// Optional macro MEM_MISALIGN_TRAP_EN: misaligned half/word accesses trap (rsp_err=1, no write).
module data_mem_responder #(
  parameter int DEPTH   = 1024,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [31:0] rsp_rdata,
  output logic        rsp_err
);
  localparam int AW = $clog2(DEPTH);
  localparam int NUM_LANES = 4;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic          we;
    logic [1:0]    size;
    logic          uns;
    logic [AW+1:0] addr;
    logic [31:0]   wdata;
  } req_t;

  state_t     state;
  req_t       req_q;
  logic [3:0] cnt;

  logic [31:0] mem [DEPTH];

  logic                 is_half, is_word, trap, do_access, mem_we;
  logic [1:0]           lane;
  logic [AW-1:0]        idx;
  logic [NUM_LANES-1:0] be;
  logic [31:0]          wword, rword, sh, ldata;

  // Upper address bits wrap modulo DEPTH and are never looked at.
  logic unused_addr;
  assign unused_addr = ^req_addr[31:AW+2];

  always_comb begin
    is_half = (req_q.size == 2'b01);
    is_word = req_q.size[1];
    idx     = req_q.addr[AW+1:2];
    // Lane is always force-aligned; the trap build decides separately whether to use it.
    lane    = is_word ? 2'b00 : is_half ? {req_q.addr[1], 1'b0} : req_q.addr[1:0];
`ifdef MEM_MISALIGN_TRAP_EN
    trap    = (is_half & req_q.addr[0]) | (is_word & (|req_q.addr[1:0]));
`else
    trap    = 1'b0;
`endif
    do_access = (state == BUSY) && (cnt == 4'd0);
    mem_we    = do_access && req_q.we && !trap;

    if (is_word) begin
      be    = 4'b1111;
      wword = req_q.wdata;
    end else if (is_half) begin
      be    = 4'b0011 << lane;
      wword = {2{req_q.wdata[15:0]}};
    end else begin
      be    = 4'b0001 << lane;
      wword = {4{req_q.wdata[7:0]}};
    end

    rword = mem[idx];
    sh    = rword >> {lane, 3'b000};
    if (is_word)      ldata = rword;
    else if (is_half) ldata = {{16{sh[15] & ~req_q.uns}}, sh[15:0]};
    else              ldata = {{24{sh[7]  & ~req_q.uns}}, sh[7:0]};
  end

  // RAM is not reset; a reset drops the FSM to IDLE so do_access cannot fire.
  always_ff @(posedge clk) begin
    for (int b = 0; b < NUM_LANES; b++)
      if (mem_we && be[b]) mem[idx][8*b +: 8] <= wword[8*b +: 8];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= '0;
      rsp_err   <= 1'b0;
      cnt       <= '0;
      req_q     <= '0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          req_q     <= '{we: req_we, size: req_size, uns: req_unsigned,
                         addr: req_addr[AW+1:0], wdata: req_wdata};
          cnt       <= 4'(LATENCY - 1);
          req_ready <= 1'b0;
          state     <= BUSY;
        end
        BUSY: if (cnt != 4'd0) begin
          cnt <= cnt - 4'd1;
        end else begin
          rsp_rdata <= (req_q.we || trap) ? 32'd0 : ldata;
          rsp_err   <= trap;
          rsp_valid <= 1'b1;
          state     <= RESP;
        end
        RESP: if (rsp_ready) begin
          rsp_valid <= 1'b0;
          req_ready <= 1'b1;
          state     <= IDLE;
        end
        default: begin
          state     <= IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end
endmodule
